// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pulls bytes from a non-show-ahead FIFO and shifts them out as
// 8N1/8N2 asynchronous frames at CLK_DIV system clocks per bit.
module uart_tx_ser #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  output logic        tx_fifo_rden,
  input  logic [7:0]  tx_fifo_rdata,
  input  logic        tx_fifo_empty,
  output logic        txd,
  output logic        busy,
  output logic        byte_done,
  output logic [15:0] tx_byte_cnt
);

  localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StLoad, StStart, StData, StStop} state_e;

  state_e      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        baud_last;

  assign baud_last = (baud_cnt == BaudLast);
  assign busy      = (state != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      txd          <= 1'b1;
      tx_fifo_rden <= 1'b0;
      byte_done    <= 1'b0;
      tx_byte_cnt  <= 16'd0;
      bit_cnt      <= 3'd0;
      baud_cnt     <= 16'd0;
      shreg        <= 8'd0;
    end else begin
      tx_fifo_rden <= 1'b0;
      byte_done    <= 1'b0;
      unique case (state)
        StIdle: begin
          txd <= 1'b1;
          if (ena && !tx_fifo_empty) begin
            tx_fifo_rden <= 1'b1;
            state        <= StRead;
          end
        end
        // FIFO data becomes valid one cycle after the read strobe.
        StRead: state <= StLoad;
        StLoad: begin
          shreg    <= tx_fifo_rdata;
          txd      <= 1'b0;
          baud_cnt <= 16'd0;
          state    <= StStart;
        end
        StStart: begin
          if (baud_last) begin
            baud_cnt <= 16'd0;
            txd      <= shreg[0];
            bit_cnt  <= 3'd0;
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt <= 16'd0;
            shreg    <= shreg >> 1;
            if (bit_cnt == 3'd7) begin
              txd     <= 1'b1;
              bit_cnt <= 3'd0;
              state   <= StStop;
            end else begin
              txd     <= shreg[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        // bit_cnt now counts stop-bit periods.
        StStop: begin
          if (baud_last) begin
            baud_cnt <= 16'd0;
            if (bit_cnt == StopLast) begin
              bit_cnt     <= 3'd0;
              byte_done   <= 1'b1;
              tx_byte_cnt <= tx_byte_cnt + 16'd1;
              state       <= StIdle;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser: 8N1 at CLK_DIV=4 and 8N2 at CLK_DIV=5, each fed by a
// one-cycle-latency FIFO model.
module tb_uart_tx_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, ena2;
  logic        rden, rden2, empty, empty2;
  logic [7:0]  rdata, rdata2;
  logic        txd, txd2, busy, busy2, bd, bd2;
  logic [15:0] cnt, cnt2;

  logic [7:0]  q[$];
  logic [7:0]  q2[$];
  int tests = 0, fails = 0;
  int cyc = 0;
  int rden_n = 0, bd_n = 0, rden_empty = 0;

  always #5 clk = ~clk;

  uart_tx_ser #(.CLK_DIV(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .tx_fifo_rden(rden), .tx_fifo_rdata(rdata),
    .tx_fifo_empty(empty), .txd(txd), .busy(busy), .byte_done(bd), .tx_byte_cnt(cnt)
  );

  uart_tx_ser #(.CLK_DIV(5), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .ena(ena2), .tx_fifo_rden(rden2), .tx_fifo_rdata(rdata2),
    .tx_fifo_empty(empty2), .txd(txd2), .busy(busy2), .byte_done(bd2), .tx_byte_cnt(cnt2)
  );

  assign empty  = (q.size() == 0);
  assign empty2 = (q2.size() == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rden) begin
      if (q.size() == 0) rden_empty <= rden_empty + 1;
      else rdata <= q.pop_front();
    end
    if (rden2) begin
      if (q2.size() == 0) rden_empty <= rden_empty + 1;
      else rdata2 <= q2.pop_front();
    end
  end

  always @(negedge clk) begin
    if (rden) rden_n <= rden_n + 1;
    if (bd)   bd_n   <= bd_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0: return txd;
      1: return txd2;
      2: return rden;
      3: return bd;
      default: return bd2;
    endcase
  endfunction

  // Advance to the next negedge, then until the selected signal equals val (bounded).
  task automatic wait_sig(input int sel, input logic val, input string tag);
    int n = 0;
    @(negedge clk);
    while (cur(sel) !== val && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cur(sel), val);
  endtask

  // Called on the first negedge showing the start bit; samples each data bit mid-period.
  task automatic decode(input int sel, input int div, input int drop, output logic [7:0] b);
    repeat (div / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (div) @(negedge clk);
      b[k] = cur(sel);
      if (k == drop) ena = 1'b0;
    end
  endtask

  initial begin
    logic [9:0]  frame;
    logic [39:0] obs_line, exp_line;
    logic [7:0]  b;
    logic        low_seen;
    int t, t2, r, rise, snap;

    rst = 1'b0; ena = 1'b0; ena2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_rden", rden, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_byte_done", bd, 1'b0);
    chk("rst_cnt", cnt, 16'd0);

    // Empty FIFO: nothing must happen even with ena high.
    rst = 1'b1; ena = 1'b1;
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    chk("empty_txd_low", low_seen, 1'b0);
    chk("empty_rden", rden_n, 0);

    // Single byte 0xA5: line is start, 1,0,1,0,0,1,0,1, stop (LSB first in time order).
    q.push_back(8'hA5);
    wait_sig(2, 1'b1, "a5_rden_timeout");
    r = cyc;
    chk("a5_busy", busy, 1'b1);
    wait_sig(0, 1'b0, "a5_start_timeout");
    chk("a5_start_latency", cyc - r, 2);
    frame = 10'b1_1010_0101_0;
    for (int i = 0; i < 40; i++) begin
      obs_line[i] = txd;
      exp_line[i] = frame[i / 4];
      @(negedge clk);
    end
    chk("a5_line", obs_line, exp_line);
    chk("a5_byte_done_at_40", bd, 1'b1);
    chk("a5_cnt", cnt, 16'd1);
    repeat (5) @(negedge clk);
    chk("a5_byte_done_n", bd_n, 1);
    chk("a5_rden_n", rden_n, 1);
    chk("a5_idle_busy", busy, 1'b0);

    // Back-to-back 0x00, 0xFF, 0x7F.
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h7F);
    wait_sig(0, 1'b0, "b2b_start0_timeout");
    t = cyc;
    decode(0, 4, -1, b);
    chk("b2b_byte0", b, 8'h00);
    wait_sig(0, 1'b1, "b2b_stop0_timeout");
    wait_sig(0, 1'b0, "b2b_start1_timeout");
    t2 = cyc;
    chk("b2b_spacing01", t2 - t, 43);
    decode(0, 4, -1, b);
    chk("b2b_byte1", b, 8'hFF);
    wait_sig(0, 1'b1, "b2b_stop1_timeout");
    wait_sig(0, 1'b0, "b2b_start2_timeout");
    chk("b2b_spacing12", cyc - t2, 43);
    decode(0, 4, -1, b);
    chk("b2b_byte2", b, 8'h7F);
    wait_sig(3, 1'b1, "b2b_done_timeout");
    repeat (20) @(negedge clk);
    chk("b2b_rden_n", rden_n, 4);
    chk("b2b_rden_when_empty", rden_empty, 0);
    chk("b2b_cnt", cnt, 16'd4);

    // ena dropped during data bit 3 with two bytes queued.
    q.push_back(8'h5A); q.push_back(8'hC3);
    wait_sig(0, 1'b0, "ena_start_timeout");
    t = cyc;
    decode(0, 4, 3, b);
    chk("ena_byte0", b, 8'h5A);
    wait_sig(3, 1'b1, "ena_done_timeout");
    chk("ena_done_time", cyc - t, 40);
    snap = rden_n;
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    chk("ena_hold_txd", low_seen, 1'b0);
    chk("ena_hold_rden", rden_n - snap, 0);
    chk("ena_hold_queue", q.size(), 1);
    ena = 1'b1;
    wait_sig(0, 1'b0, "ena_start1_timeout");
    decode(0, 4, -1, b);
    chk("ena_byte1", b, 8'hC3);
    wait_sig(3, 1'b1, "ena_done1_timeout");
    chk("ena_cnt", cnt, 16'd6);

    // Two stop bits, CLK_DIV=5.
    q2.push_back(8'h3C); q2.push_back(8'h81);
    ena2 = 1'b1;
    wait_sig(1, 1'b0, "s2_start0_timeout");
    t = cyc;
    decode(1, 5, -1, b);
    chk("s2_byte0", b, 8'h3C);
    wait_sig(1, 1'b1, "s2_stop_timeout");
    rise = cyc;
    chk("s2_stop_start", rise - t, 45);
    wait_sig(4, 1'b1, "s2_done_timeout");
    chk("s2_stop_len", cyc - rise, 10);
    wait_sig(1, 1'b0, "s2_start1_timeout");
    chk("s2_period", cyc - t, 58);
    decode(1, 5, -1, b);
    chk("s2_byte1", b, 8'h81);
    wait_sig(4, 1'b1, "s2_done1_timeout");
    chk("s2_cnt", cnt2, 16'd2);
    ena2 = 1'b0;

    // Asynchronous reset in the middle of a data bit.
    q.push_back(8'h96);
    wait_sig(0, 1'b0, "arst_start_timeout");
    repeat (10) @(negedge clk);
    chk("arst_pre_txd", txd, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_txd", txd, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cnt", cnt, 16'd0);
    chk("arst_rden", rden, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    snap = rden_n;
    repeat (50) @(negedge clk);
    chk("arst_no_reread", rden_n - snap, 0);
    chk("arst_line_idle", txd, 1'b1);

    // Counter wrap from 65535.
    force dut.tx_byte_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.tx_byte_cnt;
    q.push_back(8'h01);
    wait_sig(3, 1'b1, "wrap_done_timeout");
    chk("wrap_cnt", cnt, 16'd0);
    chk("final_rden_when_empty", rden_empty, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
